// File: rtl/press_decoder.sv
// Classifies a burst of debounced button presses as a single, double or triple press.
// Optional triple-press detection is enabled by defining PRESS_DECODER_TRIPLE_EN.
module press_decoder #(
  parameter int unsigned WINDOW_CYCLES = 4000000,
  parameter int unsigned CNT_W         = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press,
  output logic single_press,
  output logic double_press,
`ifdef PRESS_DECODER_TRIPLE_EN
  output logic triple_press,
`endif
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1
`ifdef PRESS_DECODER_TRIPLE_EN
    ,
    WAIT2 = 2'd2
`endif
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               single_q, single_d;
  logic               double_q, double_d;
  logic               busy_q, busy_d;
  logic               timeout;
`ifdef PRESS_DECODER_TRIPLE_EN
  logic               triple_q, triple_d;
`endif

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
`ifdef PRESS_DECODER_TRIPLE_EN
    triple_d = 1'b0;
`endif
    // A press always takes priority over a window expiring in the same cycle.
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (press) begin
`ifdef PRESS_DECODER_TRIPLE_EN
          state_d = WAIT2;
          cnt_d   = '0;
`else
          double_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
`endif
        end else if (timeout) begin
          single_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PRESS_DECODER_TRIPLE_EN
      WAIT2: begin
        if (press) begin
          triple_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (timeout) begin
          double_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef PRESS_DECODER_TRIPLE_EN
      triple_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      busy_q   <= busy_d;
`ifdef PRESS_DECODER_TRIPLE_EN
      triple_q <= triple_d;
`endif
    end
  end

  assign single_press = single_q;
  assign double_press = double_q;
  assign busy         = busy_q;
`ifdef PRESS_DECODER_TRIPLE_EN
  assign triple_press = triple_q;
`endif

endmodule

// File: tb/tb_press_decoder.sv
// Bench for press_decoder: directed scenarios plus random presses against a
// timestamp-based reference model (works with or without PRESS_DECODER_TRIPLE_EN).
module tb_press_decoder;

  localparam int W = 8;
`ifdef PRESS_DECODER_TRIPLE_EN
  localparam bit TRIPLE = 1'b1;
`else
  localparam bit TRIPLE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic press;
  logic single_press, double_press, busy;
  logic triple_obs;

  press_decoder #(.WINDOW_CYCLES(W), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .press        (press),
    .single_press (single_press),
    .double_press (double_press),
`ifdef PRESS_DECODER_TRIPLE_EN
    .triple_press (triple_obs),
`endif
    .busy         (busy)
  );

`ifndef PRESS_DECODER_TRIPLE_EN
  assign triple_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: an open sequence is described by its press count and the edge
  // index at which its current window started.
  int  t = 0;
  bit  m_open = 0;
  int  m_n = 0;
  int  m_start = 0;
  int  last_s_t, last_d_t, last_tr_t;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit p);
    bit es, ed, et;
    press = p;
    @(posedge clk);
    #1;
    t++;
    es = 0; ed = 0; et = 0;
    if (!rst_n) begin
      m_open = 0;
      m_n    = 0;
    end else if (p) begin
      if (!m_open) begin
        m_open  = 1;
        m_n     = 1;
        m_start = t;
      end else begin
        m_n++;
        if (TRIPLE && m_n == 2) m_start = t;
        else begin
          if (m_n == 2) ed = 1; else et = 1;
          m_open = 0;
        end
      end
    end else if (m_open && (t - m_start) == W) begin
      if (m_n == 1) es = 1; else ed = 1;
      m_open = 0;
    end
    check("single", single_press, es);
    check("double", double_press, ed);
    check("triple", triple_obs, et);
    check("busy", busy, m_open);
    if (single_press === 1'b1) last_s_t = t;
    if (double_press === 1'b1) last_d_t = t;
    if (triple_obs === 1'b1) last_tr_t = t;
    press = 1'b0;
  endtask

  task automatic clear_marks();
    last_s_t  = -1;
    last_d_t  = -1;
    last_tr_t = -1;
  endtask

  // Bit i of pat drives press on the i-th edge of the run.
  task automatic run_pattern(input logic [31:0] pat, input int len);
    for (int i = 0; i < len; i++) step(pat[i]);
  endtask

  // Asynchronous reset asserted mid-cycle, held across two edges.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_single", single_press, 1'b0);
    check("rst_double", double_press, 1'b0);
    check("rst_triple", triple_obs, 1'b0);
    check("rst_busy", busy, 1'b0);
    m_open = 0;
    m_n    = 0;
    step(0);
    step(0);
    #2;
    rst_n = 1'b1;
  endtask

  int s0;

  initial begin
    press = 1'b0;
    rst_n = 1'b0;
    clear_marks();
    #12;
    check("init_single", single_press, 1'b0);
    check("init_double", double_press, 1'b0);
    check("init_triple", triple_obs, 1'b0);
    check("init_busy", busy, 1'b0);
    #1;
    rst_n = 1'b1;
    step(0);
    step(0);

    // One press -> single pulse W edges later, busy in between.
    clear_marks();
    s0 = t + 1;
    run_pattern(32'h0000_0001, 14);
    check_int("single_latency", last_s_t, s0 + 8);
    check_int("single_no_double", last_d_t, -1);

    // Presses at 0 and 5.
    clear_marks();
    s0 = t + 1;
    run_pattern(32'h0000_0021, 20);
    check_int("p0_5_double", last_d_t, TRIPLE ? s0 + 13 : s0 + 5);
    check_int("p0_5_no_single", last_s_t, -1);

    // Presses at 0, 5, 9.
    clear_marks();
    s0 = t + 1;
    run_pattern(32'h0000_0221, 20);
    if (TRIPLE) check_int("p0_5_9_triple", last_tr_t, s0 + 9);
    else check_int("p0_5_9_single", last_s_t, s0 + 17);

    // Second press coincides with the window expiring.
    clear_marks();
    s0 = t + 1;
    run_pattern(32'h0000_0101, 20);
    check_int("coincide_no_single", last_s_t, -1);
    check_int("coincide_double", last_d_t, TRIPLE ? s0 + 16 : s0 + 8);

    // Press in the same cycle as the output pulse opens a new sequence.
    clear_marks();
    s0 = t + 1;
    run_pattern(32'h0000_0301, 22);
    if (TRIPLE) check_int("back2back_triple", last_tr_t, s0 + 9);
    else begin
      check_int("back2back_double", last_d_t, s0 + 8);
      check_int("back2back_single", last_s_t, s0 + 17);
    end

    // Reset mid-sequence discards it; later press starts fresh.
    clear_marks();
    s0 = t + 1;
    step(1);
    step(0);
    step(0);
    reset_pulse();
    while (t < s0 + 9) step(0);
    step(1);
    while (t < s0 + 20) step(0);
    check_int("post_reset_single", last_s_t, s0 + 18);
    check_int("post_reset_no_double", last_d_t, -1);

    // Random presses, including held presses and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else step($urandom_range(0, 5) == 0);
    end
    run_pattern(32'h0, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/press_decoder.md
PRESS_DECODER -- requirements
Module: press_decoder

Interface
REQ-001 Parameter WINDOW_CYCLES, default 4000000: inter-press window in clk cycles; legal range 2 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 22: window counter width in bits.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 press  input  1  one-cycle press pulse from the push-button debouncer, synchronous to clk.
REQ-006 single_press  output  1  one-cycle pulse: exactly one press in the sequence.
REQ-007 double_press  output  1  one-cycle pulse: exactly two presses in the sequence.
REQ-008 triple_press  output  1  one-cycle pulse: three presses; present only with the macro in REQ-026.
REQ-009 busy  output  1  high while a sequence is open (state not IDLE).

Function
REQ-010 States: IDLE, WAIT1 (one press seen), WAIT2 (two presses seen; reachable only with the macro).
REQ-011 Every clk cycle with press=1 counts as one press; a press held high N cycles counts as N presses.
REQ-012 IDLE + press: go to WAIT1, cnt <= 0, no output.
REQ-013 WAIT1/WAIT2, no press, cnt < WINDOW_CYCLES-1: cnt <= cnt+1, stay.
REQ-014 WAIT1, no press, cnt == WINDOW_CYCLES-1: single_press <= 1, go to IDLE.
REQ-015 WAIT1 + press, macro absent: double_press <= 1, go to IDLE.
REQ-016 WAIT1 + press, macro present: go to WAIT2, cnt <= 0 (window restarts from the second press).
REQ-017 WAIT2 + press: triple_press <= 1, go to IDLE.
REQ-018 WAIT2, no press, cnt == WINDOW_CYCLES-1: double_press <= 1, go to IDLE.
REQ-019 Press and timeout in the same cycle: press wins; no timeout output that cycle.
REQ-020 Outputs registered; each pulse high exactly one cycle, on the edge that samples the deciding event; at most one output high in any cycle.
REQ-021 Single-press latency: single_press high in cycle WINDOW_CYCLES after the edge that sampled the press.
REQ-022 A press sampled in the cycle an output pulse is high (state IDLE) opens a new sequence per REQ-012.
REQ-023 busy is a registered decode of state; busy=0 in the same cycle as any output pulse.

Reset
REQ-024 rst_n=0 asynchronously forces state IDLE, cnt 0, single_press/double_press/triple_press/busy 0, regardless of clk.
REQ-025 Reset mid-sequence discards the open sequence; no pulse emitted after release; first press after release starts a fresh sequence.

Configuration
REQ-026 Macro PRESS_DECODER_TRIPLE_EN defined: WAIT2 and triple_press exist; behaviour per REQ-016..018.
REQ-027 Macro undefined: no WAIT2, no triple_press port; second press in window yields double_press immediately (REQ-015).

Verification (WINDOW_CYCLES=8, CNT_W=4)
REQ-028 One press at cycle 0, none after -> single_press high at cycle 8 only; busy high cycles 1-7.
REQ-029 Presses at cycles 0 and 5, macro off -> double_press high at cycle 5; nothing at cycle 8 or later.
REQ-030 Presses at cycles 0, 5, 9, macro on -> triple_press high at cycle 9; presses 0 and 5 only -> double_press at cycle 13.
REQ-031 Presses at 0 and 8 (press coincides with timeout) -> no single_press; macro off double_press at 8.
REQ-032 Press at 0, rst_n low at cycle 3 for 2 cycles -> all outputs 0 immediately, no pulse afterwards; press at 10 -> single_press at 18.
REQ-033 Presses at 0 and 8 with macro off, then press at 8+1 -> new sequence; single_press at cycle 17.
